// File: rtl/bitonic_pkg.sv
// bitonic_pkg: shared constants and helpers for the bitonic sorter stages.
package bitonic_pkg;
    localparam logic DIR_ASC  = 1'b1;
    localparam logic DIR_DESC = 1'b0;
    // Widest key any stage may use; callers truncate pad_word to their own width.
    localparam int PAD_MAX_W = 256;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Pad value that sorts to the tail: all-ones when ascending, zero when descending.
    function automatic logic [PAD_MAX_W-1:0] pad_word(input logic dir);
        return {PAD_MAX_W{dir}};
    endfunction
endpackage

// File: rtl/bitonic_input_loader.sv
// bitonic_input_loader: gathers a serial word stream into an N-lane frame, pads short
// frames, and holds the frame for the first compare-and-swap column under valid/ready.
module bitonic_input_loader
    import bitonic_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N = 8,
    localparam int IDX_W = clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_dir,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [N*DATA_WIDTH-1:0] out_vec,
    output logic                    out_dir,
    output logic [IDX_W:0]          out_pad,
    output logic                    out_valid,
    input  logic                    out_ready
);
    localparam logic FILL = 1'b0;
    localparam logic HOLD = 1'b1;

    logic             state;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             frame_end;
    logic             frame_dir;
    logic [DATA_WIDTH-1:0] pad;

    assign in_ready  = rst & (state == FILL);
    assign accept    = in_valid & in_ready;
    assign frame_end = in_last | (idx == IDX_W'(N - 1));
    // The first word's direction is not yet registered when it decides the pad.
    assign frame_dir = (idx == '0) ? in_dir : out_dir;
    assign pad       = DATA_WIDTH'(pad_word(frame_dir));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= FILL;
            idx       <= '0;
            out_vec   <= '0;
            out_dir   <= 1'b0;
            out_pad   <= '0;
            out_valid <= 1'b0;
        end else if (state == FILL) begin
            if (accept) begin
                out_vec[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                if (idx == '0) out_dir <= in_dir;
                if (frame_end) begin
                    for (int j = 0; j < N; j++)
                        if (j > int'(idx)) out_vec[j*DATA_WIDTH +: DATA_WIDTH] <= pad;
                    out_pad   <= (IDX_W+1)'(N - 1 - int'(idx));
                    idx       <= '0;
                    state     <= HOLD;
                    out_valid <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end else if (out_ready) begin
            state     <= FILL;
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bitonic_input_loader.sv
// tb_bitonic_input_loader: directed and randomized checks against a frame-level queue model.
module tb_bitonic_input_loader;
    localparam int DW = 32;
    localparam int N = 8;

    logic              clk = 0;
    logic              rst;
    logic              in_valid;
    logic [DW-1:0]     in_data;
    logic              in_dir;
    logic              in_last;
    logic              in_ready;
    logic [N*DW-1:0]   out_vec;
    logic              out_dir;
    logic [3:0]        out_pad;
    logic              out_valid;
    logic              out_ready;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    bit rand_ready = 0;

    bitonic_input_loader #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_dir(in_dir),
        .in_last(in_last), .in_ready(in_ready), .out_vec(out_vec), .out_dir(out_dir),
        .out_pad(out_pad), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] lane(input int i);
        return out_vec[i*DW +: DW];
    endfunction

    // Frame-level model: words collect in a queue; a frame is emitted on last or N words.
    logic [DW-1:0] cur[$];
    logic          cur_dir;
    logic [DW-1:0] m_frame[N];
    logic          m_dir = 0;
    int            m_pad = 0;
    bit            m_hold = 0;
    bit            m_in_reset = 0;

    always @(posedge clk) begin
        if (!rst) begin
            cur.delete();
            m_hold = 0;
            m_dir = 0;
            m_pad = 0;
            m_in_reset = 1;
        end else begin
            m_in_reset = 0;
            if (m_hold) begin
                if (out_ready) m_hold = 0;
            end else if (in_valid) begin
                if (cur.size() == 0) cur_dir = in_dir;
                cur.push_back(in_data);
                if (in_last || cur.size() == N) begin
                    m_pad = N - cur.size();
                    for (int i = 0; i < N; i++)
                        m_frame[i] = (i < cur.size()) ? cur[i] : {DW{cur_dir}};
                    m_dir = cur_dir;
                    m_hold = 1;
                    cur.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [N*DW-1:0] ev;
            for (int i = 0; i < N; i++) ev[i*DW +: DW] = m_frame[i];
            chk("in_ready", {255'b0, in_ready}, {255'b0, rst && !m_hold});
            chk("out_valid", {255'b0, out_valid}, {255'b0, m_hold});
            if (m_hold) begin
                chk("out_vec", out_vec, ev);
                chk("out_dir", {255'b0, out_dir}, {255'b0, m_dir});
                chk("out_pad", {252'b0, out_pad}, 256'(m_pad));
            end
            if (m_in_reset) begin
                chk("rst_vec", out_vec, '0);
                chk("rst_dir", {255'b0, out_dir}, '0);
                chk("rst_pad", {252'b0, out_pad}, '0);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic dir, input logic last);
        int t = 0;
        in_valid = 1; in_data = d; in_dir = dir; in_last = last;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 500);
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: got in_ready=0 after %0d cycles expected 1", t);
        end
        step();
        in_valid = 0; in_last = 0;
    endtask

    task automatic release_frame();
        out_ready = 1;
        step();
        out_ready = 0;
    endtask

    task automatic pulse_reset();
        rst = 0;
        step();
        rst = 1;
    endtask

    initial begin
        logic [N*DW-1:0] snap;
        rst = 0; in_valid = 1; in_data = 32'hDEADBEEF; in_dir = 1; in_last = 0; out_ready = 0;
        step();
        chk_en = 1;
        repeat (3) step();
        chk("t1_vec", out_vec, '0);
        chk("t1_ready", {255'b0, in_ready}, '0);
        in_valid = 0;
        rst = 1;
        step();

        for (int i = 0; i < N; i++) send(DW'(7 - i), 1, i == N - 1);
        chk("t2_valid", {255'b0, out_valid}, 256'd1);
        chk("t2_lane0", {224'b0, lane(0)}, 256'd7);
        chk("t2_lane7", {224'b0, lane(7)}, 256'd0);
        chk("t2_pad", {252'b0, out_pad}, 256'd0);
        chk("t2_dir", {255'b0, out_dir}, 256'd1);
        release_frame();
        chk("t2_drop", {255'b0, out_valid}, '0);

        send(5, 1, 0); send(3, 1, 0); send(9, 1, 1);
        chk("t3a_lane0", {224'b0, lane(0)}, 256'd5);
        chk("t3a_lane2", {224'b0, lane(2)}, 256'd9);
        chk("t3a_lane3", {224'b0, lane(3)}, 256'hFFFFFFFF);
        chk("t3a_lane7", {224'b0, lane(7)}, 256'hFFFFFFFF);
        chk("t3a_pad", {252'b0, out_pad}, 256'd5);
        release_frame();
        send(5, 0, 0); send(3, 0, 0); send(9, 0, 1);
        chk("t3b_lane3", {224'b0, lane(3)}, 256'd0);
        chk("t3b_lane7", {224'b0, lane(7)}, 256'd0);
        chk("t3b_pad", {252'b0, out_pad}, 256'd5);
        chk("t3b_dir", {255'b0, out_dir}, 256'd0);
        release_frame();

        for (int i = 0; i < N; i++) send(DW'(100 + i), 1, 0);
        snap = out_vec;
        in_valid = 1; in_data = 32'h55; in_dir = 0;
        repeat (4) step();
        chk("t4_stable", out_vec, snap);
        chk("t4_ready", {255'b0, in_ready}, '0);
        chk("t4_valid", {255'b0, out_valid}, 256'd1);
        in_valid = 0;
        release_frame();
        chk("t4_ready_after", {255'b0, in_ready}, 256'd1);

        for (int i = 0; i < N; i++) begin
            send(DW'($urandom), (i == 0) ? 1'b1 : 1'b0, 0);
            step();
        end
        chk("t5_dir", {255'b0, out_dir}, 256'd1);
        release_frame();

        send(1, 1, 0); send(2, 1, 1);
        pulse_reset();
        chk("t6_hold_rst", {255'b0, out_valid}, '0);
        for (int i = 0; i < 4; i++) send(DW'(50 + i), 0, 0);
        pulse_reset();
        chk("t6_idx_rst", {255'b0, out_valid}, '0);
        for (int i = 0; i < N; i++) send(DW'(20 + i), 1, 0);
        chk("t6_lane0", {224'b0, lane(0)}, 256'd20);
        chk("t6_lane7", {224'b0, lane(7)}, 256'd27);
        release_frame();

        rand_ready = 1;
        for (int f = 0; f < 40; f++) begin
            int len = $urandom_range(1, N);
            logic dir = 1'($urandom_range(0, 1));
            for (int w = 0; w < len; w++) begin
                send(DW'($urandom), (w == 0) ? dir : 1'($urandom_range(0, 1)),
                     (w == len - 1) && (len < N || $urandom_range(0, 1) == 1));
                if ($urandom_range(0, 3) == 0) step();
                if ($urandom_range(0, 60) == 0) pulse_reset();
            end
        end
        rand_ready = 0;
        out_ready = 1;
        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
